// File: rtl/count32_sched.sv
// Two-requester round-robin scheduler that drives a 32-bit up/down/load counter.
// Optional macro COUNT32_SCHED_RCO_ABORT_EN lets the counter's rco end a RUN early.
module count32_sched #(
  parameter int WIDTH = 32,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [1:0]       a_modo,
  input  logic [WIDTH-1:0] a_d,
  input  logic [LEN_W-1:0] a_len,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [1:0]       b_modo,
  input  logic [WIDTH-1:0] b_d,
  input  logic [LEN_W-1:0] b_len,
  input  logic             abort,
  output logic             cnt_enable,
  output logic [1:0]       cnt_modo,
  output logic [WIDTH-1:0] cnt_d,
  input  logic [WIDTH-1:0] cnt_q,
  input  logic             cnt_rco,
  output logic             busy,
  output logic             done_a,
  output logic             done_b,
  output logic [WIDTH-1:0] res_q,
  output logic             res_ovf,
  output logic             res_abt,
  output logic [1:0]       dbg_state
);

  // Handshake: a job transfers on the rising edge where x_valid && x_ready.
  // x_valid must stay high (payload stable) until that edge; x_ready only rises in IDLE.

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t           state, next_state;
  logic [1:0]       job_modo;
  logic [LEN_W-1:0] remaining;
  logic             owner_b;
  logic             prio_b;
  logic             end_abt, end_ovf;
  logic             abt_set, ovf_set;
  logic             accept;
  logic             rco_in;
  logic [1:0]       sel_modo;
  logic [WIDTH-1:0] sel_d;
  logic [LEN_W-1:0] sel_len;

`ifdef COUNT32_SCHED_RCO_ABORT_EN
  assign rco_in = cnt_rco;
`else
  logic unused_rco;
  assign unused_rco = cnt_rco;
  assign rco_in     = 1'b0;
`endif

  assign busy      = (state != S_IDLE);
  assign dbg_state = state;
  assign accept    = a_ready | b_ready;
  assign sel_modo  = b_ready ? b_modo : a_modo;
  assign sel_d     = b_ready ? b_d    : a_d;
  assign sel_len   = b_ready ? b_len  : a_len;

  // prio_b holds which side wins a tie; it starts at A and flips to the non-granted side.
  always_comb begin
    next_state = state;
    a_ready    = 1'b0;
    b_ready    = 1'b0;
    abt_set    = 1'b0;
    ovf_set    = 1'b0;
    case (state)
      S_IDLE: begin
        a_ready = a_valid & (~b_valid | ~prio_b);
        b_ready = b_valid & ~(a_valid & (~b_valid | ~prio_b));
        if (a_ready | b_ready) next_state = S_LOAD;
      end
      S_LOAD: begin
        if (abort) begin
          next_state = S_DONE;
          abt_set    = 1'b1;
        end else if (job_modo == 2'b11 || remaining == '0) begin
          next_state = S_DONE;
        end else begin
          next_state = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          next_state = S_DONE;
          abt_set    = 1'b1;
        end else if (rco_in) begin
          next_state = S_DONE;
          ovf_set    = 1'b1;
        end else if (remaining == LEN_W'(1)) begin
          next_state = S_DONE;
        end
      end
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      job_modo   <= 2'b00;
      remaining  <= '0;
      owner_b    <= 1'b0;
      prio_b     <= 1'b0;
      end_abt    <= 1'b0;
      end_ovf    <= 1'b0;
      cnt_enable <= 1'b0;
      cnt_modo   <= 2'b00;
      cnt_d      <= '0;
      done_a     <= 1'b0;
      done_b     <= 1'b0;
      res_q      <= '0;
      res_ovf    <= 1'b0;
      res_abt    <= 1'b0;
    end else begin
      state <= next_state;
      if (accept) begin
        job_modo  <= sel_modo;
        remaining <= sel_len;
        owner_b   <= b_ready;
        prio_b    <= a_ready;
        cnt_d     <= sel_d;
        end_abt   <= 1'b0;
        end_ovf   <= 1'b0;
      end else begin
        if (state == S_RUN && remaining != '0) remaining <= remaining - LEN_W'(1);
        if (abt_set) end_abt <= 1'b1;
        if (ovf_set) end_ovf <= 1'b1;
      end
      // Counter controls are registered from the next state so they line up with the state.
      case (next_state)
        S_LOAD: begin
          cnt_enable <= 1'b1;
          cnt_modo   <= 2'b11;
        end
        S_RUN: begin
          cnt_enable <= 1'b1;
          cnt_modo   <= job_modo;
        end
        default: begin
          cnt_enable <= 1'b0;
          cnt_modo   <= 2'b00;
        end
      endcase
      done_a <= (state == S_DONE) & ~owner_b;
      done_b <= (state == S_DONE) & owner_b;
      if (state == S_DONE) begin
        res_q   <= cnt_q;
        res_abt <= end_abt;
        res_ovf <= end_ovf;
      end
    end
  end

endmodule
